// File: rtl/ram_master.sv
// ram_master: single-word bus initiator for a level-sensitive RAM.
// Each request is sequenced as SETUP -> STROBE -> HOLD -> DONE so the RAM
// only ever sees a stable address and data while its enable is high.
module ram_master #(
    parameter int unsigned ADDR_W        = 4,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned STROBE_CYCLES = 1,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_read_en,
    output logic              ram_write_en,
    inout  wire  [DATA_W-1:0] ram_data
);

    localparam int unsigned MAX_PHASE = (STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES;
    localparam int unsigned CNT_W     = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                wr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                drive_q;
    logic                busy_q;
    logic                done_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                ren_q;
    logic                wen_q;

    // Transaction sequencer; every output comes straight from a register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            drive_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        state_q <= ST_SETUP;
                        cnt_q   <= '0;
                        wr_q    <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        drive_q <= req_write;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    state_q <= ST_STROBE;
                    cnt_q   <= CNT_W'(STROBE_CYCLES - 1);
                    ren_q   <= ~wr_q;
                    wen_q   <= wr_q;
                end
                ST_STROBE: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= CNT_W'(HOLD_CYCLES - 1);
                        ren_q   <= 1'b0;
                        wen_q   <= 1'b0;
                        if (!wr_q) begin
                            rdata_q <= ram_data;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_DONE;
                        cnt_q   <= '0;
                        drive_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Shared data bus: driven only while a write owns it.
    assign ram_data     = drive_q ? wdata_q : {DATA_W{1'bz}};

    assign busy         = busy_q;
    assign done         = done_q;
    assign rdata        = rdata_q;
    assign ram_address  = addr_q;
    assign ram_read_en  = ren_q;
    assign ram_write_en = wen_q;

endmodule

// File: tb/tb_ram_master.sv
// Bench for ram_master: transaction-level model plus directed scenarios.
`timescale 1ns/1ps
module tb_ram_master;

    localparam int S    = 1;
    localparam int H    = 1;
    localparam int LAST = S + H + 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req = 1'b0;
    logic       req_write = 1'b0;
    logic [3:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       busy, done, ram_read_en, ram_write_en;
    logic [7:0] rdata;
    logic [3:0] ram_address;
    wire  [7:0] ram_data;

    logic       req2 = 1'b0;
    logic       busy2, done2, ram2_read_en, ram2_write_en;
    logic [7:0] rdata2;
    logic [3:0] ram2_address;
    wire  [7:0] ram2_data;

    always #5 clk = ~clk;

    ram_master dut (
        .clk(clk), .reset(reset), .req(req), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .done(done),
        .rdata(rdata), .ram_address(ram_address), .ram_read_en(ram_read_en),
        .ram_write_en(ram_write_en), .ram_data(ram_data)
    );

    ram_master #(.STROBE_CYCLES(3), .HOLD_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .req(req2), .req_write(1'b0),
        .req_addr(4'd5), .req_wdata(8'h00), .busy(busy2), .done(done2),
        .rdata(rdata2), .ram_address(ram2_address), .ram_read_en(ram2_read_en),
        .ram_write_en(ram2_write_en), .ram_data(ram2_data)
    );

    // RAM attached to the default instance, with a bench-side preload port.
    logic [7:0] ram [16];
    logic       pl_en = 1'b0;
    logic [3:0] pl_addr = '0;
    logic [7:0] pl_data = '0;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) ram[i] <= '0;
        end else if (ram_write_en) begin
            ram[ram_address] <= ram_data;
        end else if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end
    end
    assign ram_data = ram_read_en ? ram[ram_address] : 8'bz;

    // RAM for the long-strobe instance; word i holds i*0x11 after reset.
    logic [7:0] ram2 [16];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) ram2[i] <= 8'(i * 17);
        end else if (ram2_write_en) begin
            ram2[ram2_address] <= ram2_data;
        end
    end
    assign ram2_data = ram2_read_en ? ram2[ram2_address] : 8'bz;

    // Transaction model: position k of the active transaction (1 = SETUP).
    logic       m_active = 1'b0;
    int         m_k = 0;
    logic       m_wr = 1'b0;
    logic [3:0] m_addr = '0;
    logic [7:0] m_wdata = '0;
    logic [7:0] m_rdata = '0;
    logic [7:0] mmem [16];

    always @(posedge clk) begin
        if (reset) begin
            m_active = 1'b0;
            m_k      = 0;
            m_rdata  = '0;
            m_addr   = '0;
            for (int i = 0; i < 16; i++) mmem[i] = '0;
        end else begin
            if (pl_en) mmem[pl_addr] = pl_data;
            if (m_active) begin
                if (m_k == LAST) begin
                    m_active = 1'b0;
                end else begin
                    m_k = m_k + 1;
                    if (m_k == S + 2) begin
                        if (m_wr) mmem[m_addr] = m_wdata;
                        else      m_rdata = mmem[m_addr];
                    end
                end
            end else if (req) begin
                m_active = 1'b1;
                m_k      = 1;
                m_wr     = req_write;
                m_addr   = req_addr;
                m_wdata  = req_wdata;
            end
        end
    end

    logic exp_busy, exp_done, exp_ren, exp_wen, exp_drive;
    assign exp_busy  = m_active;
    assign exp_done  = m_active && (m_k == LAST);
    assign exp_ren   = m_active && !m_wr && (m_k >= 2) && (m_k <= S + 1);
    assign exp_wen   = m_active &&  m_wr && (m_k >= 2) && (m_k <= S + 1);
    assign exp_drive = m_active &&  m_wr && (m_k <= S + H + 1);

    // Probe driver: whenever the DUT must have released the bus, drive a
    // pattern disjoint from its last write data; any leak corrupts it.
    logic       chk_en = 1'b0;
    logic       probe_en;
    logic [7:0] probe_val;
    assign probe_en  = chk_en && !exp_drive && !exp_ren;
    assign probe_val = ~m_wdata;
    assign ram_data  = probe_en ? probe_val : 8'bz;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("done", 32'(done), 32'(exp_done));
            chk("read_en", 32'(ram_read_en), 32'(exp_ren));
            chk("write_en", 32'(ram_write_en), 32'(exp_wen));
            chk("address", 32'(ram_address), 32'(m_addr));
            chk("rdata", 32'(rdata), 32'(m_rdata));
            chk("inv_rw_excl", 32'(ram_read_en && ram_write_en), 32'd0);
            if (exp_drive)     chk("bus_drive", 32'(ram_data), 32'(m_wdata));
            else if (probe_en) chk("bus_release", 32'(ram_data), 32'(probe_val));
        end
    end

    task automatic wait_idle();
        @(negedge clk);
        for (int i = 0; i < 40 && m_active; i++) @(negedge clk);
    endtask

    // Issue one request and return cycles from acceptance to done.
    task automatic txn(input logic wr, input logic [3:0] a, input logic [7:0] d, output int lat);
        wait_idle();
        req = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        @(negedge clk);
        req = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic preload(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, dn, ren_cnt;
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_addr", 32'(ram_address), 32'd0);
        chk("rst_ren", 32'(ram_read_en), 32'd0);
        chk("rst_wen", 32'(ram_write_en), 32'd0);
        reset = 1'b0;

        preload(4'd14, 8'h0B);
        preload(4'd15, 8'h05);
        preload(4'd7,  8'h77);

        // Write then read back word 3.
        txn(1'b1, 4'd3, 8'h5A, lat);
        chk("wr_latency", 32'(lat), 32'd4);
        txn(1'b0, 4'd3, 8'h00, lat);
        chk("rd_latency", 32'(lat), 32'd4);
        chk("rd3_rdata", 32'(rdata), 32'h5A);
        chk("ram3", 32'(ram[3]), 32'h5A);

        // Preloaded reads; a later write leaves rdata alone.
        txn(1'b0, 4'd14, 8'h00, lat);
        chk("rd14_rdata", 32'(rdata), 32'h0B);
        txn(1'b0, 4'd15, 8'h00, lat);
        chk("rd15_rdata", 32'(rdata), 32'h05);
        txn(1'b1, 4'd13, 8'h99, lat);
        chk("wr13_rdata", 32'(rdata), 32'h05);

        // Request pulsed during STROBE of another write is ignored.
        wait_idle();
        req = 1'b1; req_write = 1'b1; req_addr = 4'd2; req_wdata = 8'h33;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) req = 1'b0;
            if (i == 1) begin
                req = 1'b1; req_write = 1'b1; req_addr = 4'd7; req_wdata = 8'hFF;
            end
            if (i == 2) req = 1'b0;
            if (done) dn++;
        end
        chk("ignored_req_dones", 32'(dn), 32'd1);
        chk("ram2_written", 32'(ram[2]), 32'h33);
        chk("ram7_untouched", 32'(ram[7]), 32'h77);

        // Random read/write mix with requests on any cycle.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            req       = ($urandom_range(0, 2) == 0);
            req_write = 1'($urandom_range(0, 1));
            req_addr  = 4'($urandom_range(0, 15));
            req_wdata = 8'($urandom_range(0, 255));
        end
        req = 1'b0;
        wait_idle();

        // Reset during STROBE of a write.
        req = 1'b1; req_write = 1'b1; req_addr = 4'd9; req_wdata = 8'hC3;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_wen", 32'(ram_write_en), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rdata", 32'(rdata), 32'd0);
        chk("midrst_addr", 32'(ram_address), 32'd0);
        reset = 1'b0;
        txn(1'b1, 4'd4, 8'h44, lat);
        chk("post_rst_latency", 32'(lat), 32'd4);
        txn(1'b0, 4'd4, 8'h00, lat);
        chk("post_rst_rdata", 32'(rdata), 32'h44);

        // Long strobe/hold instance: read word 5 (0x55 after reset).
        wait_idle();
        req2 = 1'b1;
        lat = 0;
        ren_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            req2 = 1'b0;
            lat++;
            if (ram2_read_en) ren_cnt++;
            if (done2) break;
        end
        chk("s3h2_latency", 32'(lat), 32'd7);
        chk("s3h2_ren_cycles", 32'(ren_cnt), 32'd3);
        chk("s3h2_rdata", 32'(rdata2), 32'h55);
        @(negedge clk);
        chk("s3h2_done_pulse", 32'(done2), 32'd0);
        chk("s3h2_busy_after", 32'(busy2), 32'd0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/ram_master.md
# ram_master

Bus initiator for the 16x8 level-sensitive RAM on the CPU's shared memory bus. Accepts single-word read/write requests from the control unit. Sequences each one onto `ram_address` / `ram_read_en` / `ram_write_en` / `ram_data` with setup, strobe and hold phases, so the RAM's level-sensitive write path only sees stable address and data. Returns read data with a one-cycle `done` pulse.

## Interface
Parameters:
- `ADDR_W`, 4: RAM address width.
- `DATA_W`, 8: RAM data width.
- `STROBE_CYCLES`, 1: cycles the enable is held high. Must be ≥1.
- `HOLD_CYCLES`, 1: cycles address is held stable after the enable drops. Must be ≥1; this is also the bus-turnaround time.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `req`  in  1  request valid; sampled only in IDLE.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  target word address.
- `req_wdata`  in  DATA_W  write data.
- `busy`  out  1  high from SETUP through DONE inclusive.
- `done`  out  1  one-cycle pulse marking completion.
- `rdata`  out  DATA_W  last read result.
- `ram_address`  out  ADDR_W  RAM address.
- `ram_read_en`  out  1  RAM read enable.
- `ram_write_en`  out  1  RAM write enable (level-sensitive at the RAM).
- `ram_data`  inout  DATA_W  shared data bus; driven only during writes, otherwise `z`.

## Operation
- FSM states: IDLE → SETUP → STROBE → HOLD → DONE → IDLE.
- IDLE:
  - `busy`=0; enables low; bus released.
  - On `req`=1, latch `req_write`, `req_addr` and `req_wdata` into internal registers, then go to SETUP.
- SETUP, 1 cycle:
  - `ram_address` = latched address.
  - Write: bus driven with latched data, `ram_write_en`=0.
  - Read: bus released, `ram_read_en`=0.
- STROBE, `STROBE_CYCLES` cycles:
  - Write: `ram_write_en`=1; bus still driven.
  - Read: `ram_read_en`=1; `rdata` captures `ram_data` on the edge that ends the last STROBE cycle.
- HOLD, `HOLD_CYCLES` cycles:
  - Enables low; address unchanged.
  - Write: bus still driven through HOLD.
  - Read: bus released.
- DONE, 1 cycle: `done`=1, `busy`=1, bus released; then go to IDLE.
- Between transactions:
  - `ram_address` keeps its last value in IDLE.
  - `rdata` holds until the next read completes; writes never change it.
- Invariants:
  - `ram_read_en` and `ram_write_en` are never high together.
  - The bus driver is never enabled while `ram_read_en`=1.
  - The bus driver is never enabled outside SETUP/STROBE/HOLD of a write.
- `req` outside IDLE is ignored. There is no queue, and `req` must be re-presented after `done`.
- Phase counter is wide enough for `max(STROBE_CYCLES, HOLD_CYCLES)`. It reloads on every state entry.

## Timing
- Reset:
  - `busy`=0, `done`=0, `rdata`=0, `ram_address`=0, both enables 0, bus `z`, state IDLE.
  - Effective at the first edge with `reset`=1, from any state.
- Reset mid-transaction: enables and driver drop the cycle after that edge. A write cut off during STROBE may leave the target word undefined; this is accepted.
- Latency:
  - With `req` accepted at edge E0, SETUP occupies the cycle after E0.
  - `done` is high in the cycle after edge E0+1+S+H, where S = `STROBE_CYCLES` and H = `HOLD_CYCLES`.
  - Defaults: `done` in the 4th cycle after acceptance.
- Throughput: one transaction per S+H+3 cycles. The next `req` can be accepted at the first edge after DONE.
- `rdata` is valid from the DONE cycle onward.

## Test plan
- Write 0x5A to address 3, then read address 3 (defaults, RAM model attached) → RAM word 3 = 0x5A; `rdata`=0x5A in read DONE; each `done` exactly 1 cycle, 4 cycles after acceptance.
- RAM preloaded with word 14 = 0x0B and word 15 = 0x05; read 14 then 15 → `rdata` = 0x0B then 0x05; a later write to word 13 leaves `rdata`=0x05.
- Pulse `req` (write, addr 7, 0xFF) during STROBE of a write to addr 2 → only word 2 changes; exactly one `done`; word 7 unchanged.
- `reset`=1 during STROBE of a write → next cycle: `ram_write_en`=0, bus `z`, `busy`=0, `rdata`=0, `ram_address`=0; a new request completes normally.
- `STROBE_CYCLES`=3, `HOLD_CYCLES`=2, read addr 5 → `ram_read_en` high exactly 3 cycles; `done` 7 cycles after acceptance.
- Every cycle of a random read/write mix:
  - assert not (`ram_read_en` && `ram_write_en`);
  - assert bus is `z` whenever `ram_read_en`=1 or state ∉ {SETUP, STROBE, HOLD} of a write.
